// File: rtl/mac_unit_pkg.sv
// mac_unit_pkg
//   Shared constants and types for the multiply-accumulate cell.
//   DEFAULT_DATA_WIDTH  : default signed operand width
//   accum_width_for()   : accumulator width rule (full product width)
//   data_t / accum_t    : signed types at the default widths
package mac_unit_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // The accumulator must hold at least one full-width signed product.
  function automatic int accum_width_for(input int data_width);
    return 2 * data_width;
  endfunction

  localparam int DEFAULT_ACCUM_WIDTH = accum_width_for(DEFAULT_DATA_WIDTH);

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0]  data_t;
  typedef logic signed [DEFAULT_ACCUM_WIDTH-1:0] accum_t;

endpackage

// File: rtl/mac_unit_product_stage.sv
// mac_unit_product_stage
//   First pipeline stage of the MAC cell: registers the signed product of the
//   operands (sign-extended to the accumulator width) and a delayed copy of
//   the run enable.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear of prod_q/run_q
//   run          accumulate enable, delayed into run_q
//   in1, in2     signed operands
//   prod_q       registered sign-extended product
//   run_q        run delayed by one cycle
module mac_unit_product_stage
  import mac_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ACCUM_WIDTH = accum_width_for(DATA_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          run,
  input  logic signed [DATA_WIDTH-1:0]  in1,
  input  logic signed [DATA_WIDTH-1:0]  in2,
  output logic signed [ACCUM_WIDTH-1:0] prod_q,
  output logic                          run_q
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  typedef logic signed [PROD_WIDTH-1:0]  prod_t;
  typedef logic signed [ACCUM_WIDTH-1:0] accum_w_t;

  prod_t    prod_full;
  accum_w_t prod_ext;

  // Operands are widened before multiplying so the full signed product is
  // formed without truncation.
  assign prod_full = prod_t'(in1) * prod_t'(in2);
  assign prod_ext  = accum_w_t'(prod_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      run_q  <= 1'b0;
    end else if (clr) begin
      prod_q <= '0;
      run_q  <= 1'b0;
    end else begin
      prod_q <= prod_ext;
      run_q  <= run;
    end
  end

endmodule

// File: rtl/mac_unit.sv
// mac_unit
//   Signed multiply-accumulate cell with a two-stage pipeline (registered
//   product, then accumulate), saturating accumulator and sticky overflow flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear of accumulator, pipeline and err
//   run          accumulate enable
//   in1, in2     signed operands
//   total        registered signed accumulated sum
//   err          registered sticky overflow/underflow flag
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ACCUM_WIDTH = accum_width_for(DATA_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          run,
  input  logic signed [DATA_WIDTH-1:0]  in1,
  input  logic signed [DATA_WIDTH-1:0]  in2,
  output logic signed [ACCUM_WIDTH-1:0] total,
  output logic                          err
);

  typedef logic signed [ACCUM_WIDTH-1:0] accum_w_t;
  typedef logic signed [ACCUM_WIDTH:0]   accum_x_t;

  localparam accum_w_t ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam accum_w_t ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

  accum_w_t prod_q;
  logic     run_q;
  accum_x_t sum_x;
  logic     ovf;
  logic     add_en;

  mac_unit_product_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACCUM_WIDTH (ACCUM_WIDTH)
  ) u_product_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .run    (run),
    .in1    (in1),
    .in2    (in2),
    .prod_q (prod_q),
    .run_q  (run_q)
  );

  // One guard bit: the sum left the accumulator range when the top two bits
  // disagree; the guard bit then carries the true sign for saturation.
  assign sum_x  = {total[ACCUM_WIDTH-1], total} + {prod_q[ACCUM_WIDTH-1], prod_q};
  assign ovf    = sum_x[ACCUM_WIDTH] != sum_x[ACCUM_WIDTH-1];
  // run_q qualifies that prod_q was captured on a run-high edge; once err is
  // set the saturated total is frozen until clr.
  assign add_en = run && run_q && !err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total <= '0;
      err   <= 1'b0;
    end else if (clr) begin
      total <= '0;
      err   <= 1'b0;
    end else if (add_en) begin
      if (ovf) begin
        total <= sum_x[ACCUM_WIDTH] ? ACC_MIN : ACC_MAX;
        err   <= 1'b1;
      end else begin
        total <= sum_x[ACCUM_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit
//   Directed self-checking bench for mac_unit at default widths (8/16).
module tb_mac_unit;
  import mac_unit_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   clr;
  logic   run;
  data_t  in1;
  data_t  in2;
  accum_t total;
  logic   err;

  int checks = 0;
  int errors = 0;

  mac_unit #(
    .DATA_WIDTH  (8),
    .ACCUM_WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .run   (run),
    .in1   (in1),
    .in2   (in2),
    .total (total),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int exp_total, input logic exp_err);
    check({tag, "_total"}, total, exp_total);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    run   = 1'b0;
    in1   = -8'sd1;
    in2   = -8'sd1;
    #1;
    check_state("reset_t0", 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      check_state("reset_hold", 0, 1'b0);
    end

    // Released, idle with nonzero operands
    rst_n = 1'b1;
    in1 = 8'sd1;
    in2 = 8'sd1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_total", total, 0);
    end

    // Two-cycle run performs exactly one add
    run = 1'b1;
    tick();
    check("run2_edge1", total, 0);
    tick();
    check("run2_edge2", total, 1);
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("run2_hold", total, 1);
    end

    // Clear
    clr = 1'b1;
    tick();
    check("clr_total", total, 0);
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("clr_hold", total, 0);
    end

    // 90-cycle run performs 89 adds
    run = 1'b1;
    for (int i = 0; i < 90; i++) begin
      tick();
      check("run90", total, i);
    end
    run = 1'b0;
    tick(5);
    check_state("run90_hold", 89, 1'b0);

    // Negative product accumulation
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in1 = -8'sd3;
    in2 = 8'sd5;
    run = 1'b1;
    tick();
    check("neg_edge1", total, 0);
    tick();
    check("neg_edge2", total, -15);
    tick();
    check("neg_edge3", total, -30);

    // clr beats run, and also drops run_q so the pipeline restarts
    clr = 1'b1;
    in1 = 8'sd1;
    in2 = 8'sd1;
    tick();
    check_state("clr_prio", 0, 1'b0);
    clr = 1'b0;
    tick();
    check("clr_restart1", total, 0);
    tick();
    check("clr_restart2", total, 1);

    // Overflow: (-128)*(-128) = 16384, second add saturates
    run = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in1 = -8'sd128;
    in2 = -8'sd128;
    run = 1'b1;
    tick();
    check_state("ovf1_e1", 0, 1'b0);
    tick();
    check_state("ovf1_e2", 16384, 1'b0);
    tick();
    check_state("ovf1_e3", 32767, 1'b1);
    tick();
    check_state("ovf1_sticky", 32767, 1'b1);
    run = 1'b0;
    tick(3);
    check_state("ovf1_hold", 32767, 1'b1);

    // Clear drops err; then 127*127 = 16129, third add saturates
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("ovf2_idle", 0, 1'b0);
    end
    in1 = 8'sd127;
    in2 = 8'sd127;
    run = 1'b1;
    tick();
    check_state("ovf2_e1", 0, 1'b0);
    tick();
    check_state("ovf2_e2", 16129, 1'b0);
    tick();
    check_state("ovf2_e3", 32258, 1'b0);
    tick();
    check_state("ovf2_e4", 32767, 1'b1);

    // Underflow: -128*127 = -16256, third add saturates low
    clr = 1'b1;
    tick();
    check_state("unf_clr", 0, 1'b0);
    clr = 1'b0;
    in1 = -8'sd128;
    in2 = 8'sd127;
    tick();
    check_state("unf_e1", 0, 1'b0);
    tick();
    check_state("unf_e2", -16256, 1'b0);
    tick();
    check_state("unf_e3", -32512, 1'b0);
    tick();
    check_state("unf_e4", -32768, 1'b1);
    run = 1'b0;
    tick(3);
    check_state("unf_hold", -32768, 1'b1);

    // Asynchronous reset mid-accumulation
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in1 = 8'sd3;
    in2 = 8'sd5;
    run = 1'b1;
    tick();
    tick();
    check("mid_e2", total, 15);
    tick();
    check("mid_e3", total, 30);
    #2 rst_n = 1'b0;
    #1;
    check_state("mid_async_rst", 0, 1'b0);
    tick();
    check_state("mid_rst_edge", 0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("mid_restart1", total, 0);
    tick();
    check("mid_restart2", total, 15);
    run = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
- Signed multiply-accumulate block: each enabled cycle it multiplies two signed operands and adds the product into a signed accumulator.
- Two-stage pipeline: registered product, then accumulate.
- Sticky overflow flag; synchronous clear.
- Used as the per-element compute cell of the matrix multiplier datapath.

Parameters:
- DATA_WIDTH, 8, width of each signed operand in1/in2.
- ACCUM_WIDTH, 2*DATA_WIDTH, width of the signed accumulator/total; must be >= 2*DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of accumulator, pipeline and err.
- run  input  1  accumulate enable.
- in1  input  DATA_WIDTH  signed operand A.
- in2  input  DATA_WIDTH  signed operand B.
- total  output  ACCUM_WIDTH  signed accumulated sum (registered).
- err  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0: total=0, err=0, prod_q=0, run_q=0, regardless of other inputs.
- Stage 1, every rising edge:
  - prod_q <= in1*in2, full 2*DATA_WIDTH signed product, sign-extended to ACCUM_WIDTH.
  - run_q <= run.
- Stage 2: accumulate only when run=1 AND run_q=1, i.e. total <= total + prod_q.
  - Consequence: a run pulse held for N consecutive cycles performs N-1 additions.
  - First add occurs on the 2nd run-high edge and uses the product captured on the 1st.
  - Required counts: N=2 gives 1 add; N=90 gives 89 adds.
- run=0: total and err hold.
- clr=1 at a rising edge:
  - total <= 0, err <= 0, prod_q <= 0, run_q <= 0.
  - clr has priority over run; no add occurs that cycle.
- Overflow detection:
  - Compute the sum in ACCUM_WIDTH+1 bits.
  - Overflow when the result exceeds 2^(ACCUM_WIDTH-1)-1 or falls below -2^(ACCUM_WIDTH-1).
  - On overflow: err <= 1 at that same edge, and total saturates to the signed max (positive) or min (negative).
- err is sticky:
  - Remains 1 until clr or reset.
  - While err=1, total holds its saturated value; further adds are ignored.
- Outputs are registered, with no combinational path from inputs to total/err.
- Reset asserted mid-accumulation: immediate return to all-zero state; accumulation restarts only after run is high for 2 edges.

Decomposition:
- Shared package holds:
  - the default DATA_WIDTH (8) constant;
  - the derived ACCUM_WIDTH rule (2*DATA_WIDTH);
  - signed data_t/accum_t typedefs for the default widths.
- Parameterised signed types are declared locally in the module from its parameters.
- No sub-module required. Optionally factor stage 1 into mac_product_stage (product + valid register); the accumulator/saturation stays in mac_unit.

Test Plan:
- Reset held 100 cycles, in1=in2=-1, run=0 -> total=16'h0000, err=0 throughout.
- rst_n released, run=0, in1=in2=1 for 100 cycles -> total stays 0.
- run=1 for 2 cycles, in1=in2=1, then run=0 -> total=1, held for 20 cycles.
- clr=1 one cycle -> total=0 next edge, stays 0 for 20 cycles.
- run=1 for 90 cycles, in1=in2=1 -> total=89, held after run drops.
- Overflow cases, each preceded by clr:
  - in1=in2=-128, run=1 -> err=1 within 4 cycles (2nd add), total=32767.
  - clr, then run=0 -> err=0 for 5 cycles; then in1=in2=127, run=1 -> err=1 within 5 cycles (3rd add).
  - in1=-128, in2=127 -> err=1 within 5 cycles (underflow), total=-32768.
